// File: rtl/rsa_msg_ctrl.sv
// ---------------------------------------------------------------------------
// rsa_msg_ctrl
// Message controller for an external modular-exponentiation core. Plaintext
// words are queued in an input FIFO. Each one is dispatched to the core
// together with the exponent and modulus sampled at dispatch time. Results
// come back into an output FIFO in the order the words were accepted.
//
// Ports
//   i_clk, i_rstn            clock, asynchronous active-low reset
//   i_exp, i_N               exponent / modulus, sampled when a word is loaded
//   i_in_valid/o_in_ready    plaintext write handshake, data on i_in_data
//   o_out_valid/i_out_ready  result read handshake, o_out_data is the FIFO head
//   o_core_start             level start to the core (high in ISSUE/WAIT_END)
//   o_core_base/exp/N        operands held stable for the core
//   i_core_result/i_core_end core result and done level
//   o_busy                   FSM not idle
//   o_err / i_err_clr        sticky modulus-zero flag and its clear
// ---------------------------------------------------------------------------
module rsa_msg_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [31:0] i_exp,
  input  logic [31:0] i_N,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_in_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_data,
  output logic        o_core_start,
  output logic [31:0] o_core_base,
  output logic [31:0] o_core_exp,
  output logic [31:0] o_core_N,
  input  logic [31:0] i_core_result,
  input  logic        i_core_end,
  output logic        o_busy,
  output logic        o_err,
  input  logic        i_err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_END, WAIT_FALL, PUSH} state_t;

  state_t state_reg, state_next;

  logic [31:0]   in_mem  [DEPTH];
  logic [31:0]   out_mem [DEPTH];
  logic [AW-1:0] in_wr_ptr_reg, in_rd_ptr_reg, out_wr_ptr_reg, out_rd_ptr_reg;
  logic [CW-1:0] in_count_reg, out_count_reg;
  logic [31:0]   base_reg, exp_reg, n_reg, result_reg;
  logic          err_reg;

  logic in_wr, in_pop, out_push, out_rd;

  assign o_in_ready  = (in_count_reg < CNT_FULL);
  assign o_out_valid = (out_count_reg != '0);
  assign in_wr       = i_in_valid && o_in_ready;
  assign out_rd      = o_out_valid && i_out_ready;
  assign in_pop      = (state_reg == LOAD);
  assign out_push    = (state_reg == PUSH);

  // Head is forced to zero while empty so the output is clean after reset
  // even though the storage itself is never cleared.
  assign o_out_data  = o_out_valid ? out_mem[out_rd_ptr_reg] : '0;

  assign o_core_base = base_reg;
  assign o_core_exp  = exp_reg;
  assign o_core_N    = n_reg;
  assign o_err       = err_reg;

  // FIFO storage: no reset, pointers alone define contents.
  always_ff @(posedge i_clk) begin
    if (in_wr)    in_mem[in_wr_ptr_reg]   <= i_in_data;
    if (out_push) out_mem[out_wr_ptr_reg] <= result_reg;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg      <= IDLE;
      in_wr_ptr_reg  <= '0;
      in_rd_ptr_reg  <= '0;
      out_wr_ptr_reg <= '0;
      out_rd_ptr_reg <= '0;
      in_count_reg   <= '0;
      out_count_reg  <= '0;
      base_reg       <= '0;
      exp_reg        <= '0;
      n_reg          <= '0;
      result_reg     <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (in_wr)    in_wr_ptr_reg  <= in_wr_ptr_reg + PTR_ONE;
      if (in_pop)   in_rd_ptr_reg  <= in_rd_ptr_reg + PTR_ONE;
      if (out_push) out_wr_ptr_reg <= out_wr_ptr_reg + PTR_ONE;
      if (out_rd)   out_rd_ptr_reg <= out_rd_ptr_reg + PTR_ONE;

      case ({in_wr, in_pop})
        2'b10:   in_count_reg <= in_count_reg + CNT_ONE;
        2'b01:   in_count_reg <= in_count_reg - CNT_ONE;
        default: ;
      endcase
      case ({out_push, out_rd})
        2'b10:   out_count_reg <= out_count_reg + CNT_ONE;
        2'b01:   out_count_reg <= out_count_reg - CNT_ONE;
        default: ;
      endcase

      // Operands are captured only here, so later i_exp/i_N changes cannot
      // disturb a transaction already in flight.
      if (state_reg == LOAD) begin
        base_reg <= in_mem[in_rd_ptr_reg];
        exp_reg  <= i_exp;
        n_reg    <= i_N;
        if (i_N == '0) result_reg <= '0;
      end

      // The core result is only trusted once its end level has dropped.
      if (state_reg == WAIT_FALL && !i_core_end) result_reg <= i_core_result;

      // Setting takes priority over a clear in the same cycle.
      if (state_reg == LOAD && i_N == '0) err_reg <= 1'b1;
      else if (i_err_clr)                 err_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next   = state_reg;
    o_core_start = 1'b0;
    o_busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        // Only dispatch when the result is guaranteed a slot on return.
        if (in_count_reg != '0 && out_count_reg < CNT_FULL) state_next = LOAD;
      end
      LOAD:      state_next = (i_N == '0) ? PUSH : ISSUE;
      ISSUE: begin
        o_core_start = 1'b1;
        state_next   = WAIT_END;
      end
      WAIT_END: begin
        o_core_start = 1'b1;
        if (i_core_end) state_next = WAIT_FALL;
      end
      WAIT_FALL: begin
        if (!i_core_end) state_next = PUSH;
      end
      PUSH:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

endmodule
